// File: rtl/sonar_trigger_ctrl_if.sv
// Signal bundle between the sonar trigger controller and its sensor/host side.
// Valid/ready is not used here: start/continuous are levels sampled in IDLE, echo_rise/done are 1-cycle strobes, err is valid with done.
interface sonar_trigger_ctrl_if;
    logic       start;
    logic       continuous;
    logic       echo;
    logic       trigger;
    logic       busy;
    logic       echo_rise;
    logic       done;
    logic [1:0] err;
    logic [2:0] dbg_state;

    modport master (
        input  start, continuous, echo,
        output trigger, busy, echo_rise, done, err, dbg_state
    );

    modport slave (
        output start, continuous, echo,
        input  trigger, busy, echo_rise, done, err, dbg_state
    );
endinterface

// File: rtl/sonar_trigger_ctrl.sv
// HC-SR04 initiator: fires a trigger pulse, brackets the echo with timeouts,
// reports per-shot status and enforces a holdoff between shots.
module sonar_trigger_ctrl #(
    parameter int CLK_PERIOD_NS  = 20,
    parameter int TRIG_CYCLES    = 500,
    parameter int RISE_MAX       = 50_000,
    parameter int ECHO_MAX       = 1_900_000,
    parameter int HOLDOFF_CYCLES = 2_500_000,
    parameter int CNT_W          = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    sonar_trigger_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    localparam int CNT_MAX_A = (TRIG_CYCLES > RISE_MAX) ? TRIG_CYCLES : RISE_MAX;
    localparam int CNT_MAX_B = (ECHO_MAX > HOLDOFF_CYCLES) ? ECHO_MAX : HOLDOFF_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;

    // Refuse to elaborate with a counter too narrow for the longest interval.
    if (CLK_PERIOD_NS <= 0 || CNT_W < $clog2(CNT_MAX + 1)) begin : g_bad_params
        $error("sonar_trigger_ctrl: CNT_W too small or CLK_PERIOD_NS invalid");
    end

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RISE_LIM  = CNT_W'(RISE_MAX);
    localparam logic [CNT_W-1:0] ECHO_LIM  = CNT_W'(ECHO_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             echo_m, echo_s, echo_d;
    logic             echo_r, echo_f;
    logic             trig_q;
    logic [1:0]       err_q, err_c;
    logic             done_c, rise_c;

    // echo is asynchronous; echo_d is only the edge-detect history of echo_s.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= bus.echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign echo_r = echo_s & ~echo_d;
    assign echo_f = ~echo_s & echo_d;

    always_comb begin
        state_nx = state;
        done_c   = 1'b0;
        rise_c   = 1'b0;
        err_c    = err_q;
        unique case (state)
            IDLE: begin
                if (bus.start || bus.continuous) state_nx = TRIG;
            end
            TRIG: begin
                if (cnt == TRIG_LAST) state_nx = WAIT_RISE;
            end
            WAIT_RISE: begin
                // An edge on the timeout cycle still counts as a rise.
                if (echo_r) begin
                    rise_c   = 1'b1;
                    state_nx = WAIT_FALL;
                end else if (cnt == RISE_LIM) begin
                    done_c   = 1'b1;
                    err_c    = 2'b01;
                    state_nx = HOLDOFF;
                end
            end
            WAIT_FALL: begin
                if (echo_f) begin
                    done_c   = 1'b1;
                    err_c    = 2'b00;
                    state_nx = HOLDOFF;
                end else if (cnt == ECHO_LIM) begin
                    done_c   = 1'b1;
                    err_c    = 2'b10;
                    state_nx = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt == HOLD_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            trig_q <= 1'b0;
            err_q  <= 2'b00;
        end else begin
            state <= state_nx;
            if (state_nx != state)  cnt <= '0;
            else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
            trig_q <= (state_nx == TRIG);
            err_q  <= err_c;
        end
    end

    assign bus.trigger   = trig_q;
    assign bus.busy      = (state != IDLE);
    assign bus.echo_rise = rise_c;
    assign bus.done      = done_c;
    assign bus.err       = err_c;
    assign bus.dbg_state = state;

endmodule
